// File: rtl/grey_timestamp_sync.sv
// Synchronizes a grey-coded timestamp from a foreign clock domain, decodes it to binary,
// and offers a capture port. Optional multi-bit jump detector: GREY_TIMESTAMP_SYNC_JUMP_CHECK_EN.
module grey_timestamp_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] in_grey,
    output logic [WIDTH-1:0] out_binary,
    output logic             out_valid,
    input  logic             capture_req,
    output logic [WIDTH-1:0] capture_value,
    output logic             capture_ack,
    input  logic             err_clr
`ifdef GREY_TIMESTAMP_SYNC_JUMP_CHECK_EN
    ,
    output logic             out_step_err
`endif
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  grey_sync;
    logic [WIDTH-1:0]                  bin_d;
    logic [WIDTH-1:0]                  out_binary_q;
    logic                              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]                  capture_value_q, capture_value_d;
    logic                              capture_ack_q, capture_ack_d;

    // Pure flop chain: nothing may sit between stages or metastability can escape.
    // NOTE: every synchronizer stage is reset so no stale foreign-domain value survives reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_grey};
        end
    end

    assign grey_sync = sync_q[SYNC_STAGES-1];

    // Binary bit i is the parity of all grey bits at or above i.
    for (genvar i = 0; i < WIDTH; i++) begin : g_decode
        assign bin_d[i] = ^grey_sync[WIDTH-1:i];
    end

    always_comb begin
        out_valid_d     = (bin_d != out_binary_q);
        capture_ack_d   = capture_req;
        capture_value_d = capture_value_q;
        if (capture_req) begin
            capture_value_d = out_binary_q;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_binary_q    <= '0;
            out_valid_q     <= 1'b0;
            capture_value_q <= '0;
            capture_ack_q   <= 1'b0;
        end else begin
            out_binary_q    <= bin_d;
            out_valid_q     <= out_valid_d;
            capture_value_q <= capture_value_d;
            capture_ack_q   <= capture_ack_d;
        end
    end

    assign out_binary    = out_binary_q;
    assign out_valid     = out_valid_q;
    assign capture_value = capture_value_q;
    assign capture_ack   = capture_ack_q;

`ifdef GREY_TIMESTAMP_SYNC_JUMP_CHECK_EN
    localparam int PRIME_CYCLES = SYNC_STAGES + 1;
    localparam int PW           = $clog2(PRIME_CYCLES + 1);

    logic [PW-1:0]    prime_q, prime_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] diff;
    logic             primed;
    logic             multi_bit;
    logic             step_err_q, step_err_d;

    // The pipeline fills from zero after reset, so early steps are not real jumps.
    assign primed    = (prime_q == PW'(PRIME_CYCLES));
    assign diff      = grey_sync ^ prev_q;
    assign multi_bit = ((diff & (diff - WIDTH'(1))) != '0);

    always_comb begin
        prime_d = prime_q;
        if (!primed) begin
            prime_d = prime_q + PW'(1);
        end
        // Set has priority over clear so a coinciding jump is never lost.
        step_err_d = (primed && multi_bit) || (step_err_q && !err_clr);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prime_q    <= '0;
            prev_q     <= '0;
            step_err_q <= 1'b0;
        end else begin
            prime_q    <= prime_d;
            prev_q     <= grey_sync;
            step_err_q <= step_err_d;
        end
    end

    assign out_step_err = step_err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_grey_timestamp_sync.sv
// Scoreboard bench for grey_timestamp_sync (WIDTH=8, SYNC_STAGES=2); error-flag tests
// run when GREY_TIMESTAMP_SYNC_JUMP_CHECK_EN is defined.
module tb_grey_timestamp_sync;

    localparam int W   = 8;
    localparam int S   = 2;
    localparam int LAT = S + 1;

    typedef struct {
        logic [W-1:0] value;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [W-1:0] in_grey = '0;
    logic [W-1:0] out_binary;
    logic         out_valid;
    logic         capture_req = 1'b0;
    logic [W-1:0] capture_value;
    logic         capture_ack;
    logic         err_clr = 1'b0;
`ifdef GREY_TIMESTAMP_SYNC_JUMP_CHECK_EN
    logic         out_step_err;
`endif

    grey_timestamp_sync #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_grey       (in_grey),
        .out_binary    (out_binary),
        .out_valid     (out_valid),
        .capture_req   (capture_req),
        .capture_value (capture_value),
        .capture_ack   (capture_ack),
        .err_clr       (err_clr)
`ifdef GREY_TIMESTAMP_SYNC_JUMP_CHECK_EN
        ,
        .out_step_err  (out_step_err)
`endif
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           valid_count = 0;
    logic [W-1:0] last_g = '0;
    logic [W-1:0] seen_bin = '0;
    logic [W-1:0] seen_cap = '0;
    exp_t         val_q[$];
    exp_t         cap_q[$];
    exp_t         e_v, e_c;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: binary is the XOR of all right-shifts of the grey code.
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int k = 1; k < W; k++) b = b ^ (g >> k);
        return b;
    endfunction

    function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every distinct value sampled by the DUT must emerge once, LAT edges later.
    task automatic drive(input logic [W-1:0] g);
        in_grey = g;
        if (g != last_g) val_q.push_back('{gray2bin(g), cyc + LAT});
        last_g = g;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            capture_req = 1'b1;
            cap_q.push_back('{gray2bin(last_g), cyc + 1});
            step();
        end
        capture_req = 1'b0;
    endtask

    function automatic logic err_bit();
`ifdef GREY_TIMESTAMP_SYNC_JUMP_CHECK_EN
        return out_step_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_zero(input string name);
        check(name, out_binary == '0 && !out_valid && capture_value == '0 && !capture_ack && !err_bit(),
              $sformatf("bin=%h valid=%b cap=%h ack=%b err=%b, required all 0",
                        out_binary, out_valid, capture_value, capture_ack, err_bit()));
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, then releases with grey g applied.
    task automatic apply_reset(input logic [W-1:0] g);
        #2;
        resetn = 1'b0;
        val_q.delete();
        cap_q.delete();
        #1;
        check_zero("async_reset");
        in_grey     = g;
        capture_req = 1'b0;
        err_clr     = 1'b0;
        step(3);
        check_zero("reset_hold");
        resetn = 1'b1;
        last_g = '0;
        drive(g);
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            seen_bin = '0;
            seen_cap = '0;
        end else begin
            if (out_valid) begin
                valid_count++;
                if (val_q.size() == 0) begin
                    check("valid_unexpected", 1'b0, $sformatf("out_binary=%h at cycle %0d, none pending", out_binary, cyc));
                end else begin
                    e_v = val_q.pop_front();
                    check("valid_value", out_binary == e_v.value && cyc == e_v.due,
                          $sformatf("got %h at cycle %0d, required %h at cycle %0d", out_binary, cyc, e_v.value, e_v.due));
                end
                seen_bin = out_binary;
            end else begin
                check("binary_hold", out_binary == seen_bin,
                      $sformatf("out_binary=%h without valid, required %h", out_binary, seen_bin));
            end
            if (capture_ack) begin
                if (cap_q.size() == 0) begin
                    check("ack_unexpected", 1'b0, $sformatf("capture_value=%h at cycle %0d, none pending", capture_value, cyc));
                end else begin
                    e_c = cap_q.pop_front();
                    check("capture_value", capture_value == e_c.value && cyc == e_c.due,
                          $sformatf("got %h at cycle %0d, required %h at cycle %0d", capture_value, cyc, e_c.value, e_c.due));
                end
                seen_cap = capture_value;
            end else begin
                check("capture_hold", capture_value == seen_cap,
                      $sformatf("capture_value=%h without ack, required %h", capture_value, seen_cap));
            end
        end
    end

    initial begin
        int base;
        logic [W-1:0] b;
        step(2);
        check_zero("power_on_reset");

        // Reset, then settle at grey 0x0C and hold.
        apply_reset(8'h0C);
        step(8);
        check("settled_0c", out_binary == 8'h08 && val_q.size() == 0,
              $sformatf("out_binary=%h pending=%0d, required 08 and 0", out_binary, val_q.size()));

        // Single-bit step 0x0C -> 0x0D.
        drive(8'h0D);
        step(6);
        check("step_0d", out_binary == 8'h09 && !err_bit(),
              $sformatf("out_binary=%h err=%b, required 09 and 0", out_binary, err_bit()));

        capture(1);
        step(3);
        capture(3);
        step(3);
        check("captures_drained", cap_q.size() == 0, $sformatf("pending=%0d, required 0", cap_q.size()));

        // Reset in the middle of a held capture.
        capture_req = 1'b1;
        cap_q.push_back('{gray2bin(last_g), cyc + 1});
        step();
        check("ack_before_reset", capture_ack && capture_value == 8'h09,
              $sformatf("ack=%b cap=%h, required 1 and 09", capture_ack, capture_value));
        apply_reset(8'h0D);
        step(8);
        check("after_mid_reset", out_binary == 8'h09 && val_q.size() == 0 && cap_q.size() == 0,
              $sformatf("out_binary=%h pending=%0d/%0d, required 09 and 0/0", out_binary, val_q.size(), cap_q.size()));

        // Full grey count with wrap-around.
        apply_reset(8'h00);
        step(6);
        base = valid_count;
        for (int i = 1; i < 256; i++) begin
            drive(bin2gray(W'(i)));
            step();
        end
        drive(8'h00);
        step(6);
        check("full_count_pulses", valid_count - base == 256 && !err_bit() && out_binary == 8'h00,
              $sformatf("pulses=%0d err=%b bin=%h, required 256, 0, 00", valid_count - base, err_bit(), out_binary));

`ifdef GREY_TIMESTAMP_SYNC_JUMP_CHECK_EN
        apply_reset(8'h0C);
        step(6);
        check("no_err_after_prime", !out_step_err, $sformatf("err=%b, required 0", out_step_err));
        drive(8'h03);
        step(4);
        check("jump_sets_err", out_step_err, $sformatf("err=%b, required 1", out_step_err));
        step(3);
        check("err_sticky", out_step_err, $sformatf("err=%b, required 1", out_step_err));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_cleared", !out_step_err, $sformatf("err=%b, required 0", out_step_err));
        drive(8'h0C);
        step(2);
        check("no_early_err", !out_step_err, $sformatf("err=%b, required 0", out_step_err));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("set_wins", out_step_err, $sformatf("err=%b, required 1", out_step_err));
        step(4);
`endif

        // Randomized counting, jumps and captures.
        for (int r = 0; r < 60; r++) begin
            case ($urandom_range(2, 0))
                0: begin
                    b = gray2bin(last_g) + W'(1);
                    drive(bin2gray(b));
                    step(int'($urandom_range(3, 1)));
                end
                1: begin
                    step(4);
                    capture(int'($urandom_range(3, 1)));
                end
                default: begin
                    drive(W'($urandom_range(255, 0)));
                    step(int'($urandom_range(4, 1)));
                end
            endcase
        end
        step(6);
        check("final_drain", val_q.size() == 0 && cap_q.size() == 0,
              $sformatf("pending=%0d/%0d, required 0/0", val_q.size(), cap_q.size()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
